// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the unified_mem port between the I-cache fill
// path and the D-cache miss/write-back path; all memory strobes are registered.
module mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t            state, state_nxt;
  side_t             last_served, last_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic              re_nxt, we_nxt, i_done_nxt, d_done_nxt;
  logic              i_elig, d_elig, grant_i, grant_d;

  // A side whose done is high this cycle is dropping its request; never re-grant it.
  assign i_elig  = i_req && !i_done;
  assign d_elig  = d_req && !d_done;
  assign grant_d = d_elig && (!i_elig || last_served == SIDE_I);
  assign grant_i = i_elig && !grant_d;

  always_comb begin
    state_nxt   = state;
    last_nxt    = last_served;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    re_nxt      = mem_re;
    we_nxt      = mem_we;
    i_done_nxt  = 1'b0;
    d_done_nxt  = 1'b0;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = GRANT_D;
          last_nxt  = SIDE_D;
          addr_nxt  = d_addr;
          wdata_nxt = d_wdata;
          re_nxt    = !d_we;
          we_nxt    = d_we;
        end else if (grant_i) begin
          state_nxt = GRANT_I;
          last_nxt  = SIDE_I;
          addr_nxt  = i_addr;
          re_nxt    = 1'b1;
          we_nxt    = 1'b0;
        end
      end
      GRANT_I: begin
        if (mem_rdy) begin
          state_nxt   = IDLE;
          re_nxt      = 1'b0;
          we_nxt      = 1'b0;
          i_done_nxt  = 1'b1;
          i_rdata_nxt = mem_rd_data;
        end
      end
      GRANT_D: begin
        if (mem_rdy) begin
          state_nxt  = IDLE;
          re_nxt     = 1'b0;
          we_nxt     = 1'b0;
          d_done_nxt = 1'b1;
          if (mem_re) d_rdata_nxt = mem_rd_data;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= SIDE_I;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      mem_addr    <= addr_nxt;
      mem_wdata   <= wdata_nxt;
      mem_re      <= re_nxt;
      mem_we      <= we_nxt;
      i_done      <= i_done_nxt;
      d_done      <= d_done_nxt;
      i_rdata     <= i_rdata_nxt;
      d_rdata     <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-side transfers, round-robin order,
// reset abort and idle mem_rdy, all against hand-computed expectations.
module tb_mem_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req, d_req, d_we, mem_rdy;
  logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] d_wdata, mem_rd_data, i_rdata, d_rdata, mem_wdata;
  logic              i_done, d_done, mem_re, mem_we;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_i_done"},  64'(i_done), 64'd0);
    chk({tag, "_d_done"},  64'(d_done), 64'd0);
    chk({tag, "_re"},      64'(mem_re), 64'd0);
    chk({tag, "_we"},      64'(mem_we), 64'd0);
    chk({tag, "_addr"},    64'(mem_addr), 64'd0);
    chk({tag, "_wdata"},   mem_wdata, 64'd0);
    chk({tag, "_i_rdata"}, i_rdata, 64'd0);
    chk({tag, "_d_rdata"}, d_rdata, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Expected grant order with both sides requesting continuously.
  logic        exp_side_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [63:0] rr_data    [4] = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                                  64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};

  initial begin
    i_req = 0; d_req = 0; d_we = 0; mem_rdy = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rd_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    all_zero("reset");
    rst_n = 1'b1;

    // I-only read, mem_rdy on the third strobe cycle
    i_req = 1; i_addr = 14'h0123;
    tick();
    chk("i_c1_re", 64'(mem_re), 64'd1);
    chk("i_c1_we", 64'(mem_we), 64'd0);
    chk("i_c1_addr", 64'(mem_addr), 64'h0123);
    tick();
    chk("i_c2_re", 64'(mem_re), 64'd1);
    chk("i_c2_done", 64'(i_done), 64'd0);
    tick();
    chk("i_c3_re", 64'(mem_re), 64'd1);
    chk("i_c3_addr", 64'(mem_addr), 64'h0123);
    mem_rdy = 1; mem_rd_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    chk("i_c4_done", 64'(i_done), 64'd1);
    chk("i_c4_rdata", i_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("i_c4_re", 64'(mem_re), 64'd0);
    chk("i_c4_we", 64'(mem_we), 64'd0);
    i_req = 0; mem_rdy = 0; mem_rd_data = '0;
    tick();
    chk("i_c5_done", 64'(i_done), 64'd0);
    chk("i_c5_no_regrant", 64'(mem_re), 64'd0);
    tick();
    chk("i_c6_no_regrant", 64'(mem_re), 64'd0);
    chk("i_c6_rdata_held", i_rdata, 64'hAAAA_BBBB_CCCC_DDDD);

    // D write-back
    d_req = 1; d_we = 1; d_addr = 14'h3FFF; d_wdata = 64'h1122_3344_5566_7788;
    tick();
    chk("dw_we", 64'(mem_we), 64'd1);
    chk("dw_re", 64'(mem_re), 64'd0);
    chk("dw_addr", 64'(mem_addr), 64'h3FFF);
    chk("dw_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    tick();
    chk("dw_hold_we", 64'(mem_we), 64'd1);
    mem_rdy = 1; mem_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    chk("dw_done", 64'(d_done), 64'd1);
    chk("dw_rdata_kept", d_rdata, 64'd0);
    chk("dw_we_clr", 64'(mem_we), 64'd0);
    d_req = 0; d_we = 0; mem_rdy = 0;
    tick();
    chk("dw_done_once", 64'(d_done), 64'd0);
    chk("dw_idle_we", 64'(mem_we), 64'd0);

    // Round robin from reset, both sides requesting continuously
    do_reset();
    i_req = 1; i_addr = 14'h0AAA;
    d_req = 1; d_we = 0; d_addr = 14'h0555;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("rr%0d_addr", g), 64'(mem_addr), exp_side_d[g] ? 64'h0555 : 64'h0AAA);
      chk($sformatf("rr%0d_re", g), 64'(mem_re), 64'd1);
      chk($sformatf("rr%0d_dones", g), {62'd0, i_done, d_done}, 64'd0);
      mem_rdy = 1; mem_rd_data = rr_data[g];
      tick();
      mem_rdy = 0;
      chk($sformatf("rr%0d_d_done", g), 64'(d_done), 64'(exp_side_d[g]));
      chk($sformatf("rr%0d_i_done", g), 64'(i_done), 64'(!exp_side_d[g]));
      if (exp_side_d[g]) chk($sformatf("rr%0d_d_rdata", g), d_rdata, rr_data[g]);
      else               chk($sformatf("rr%0d_i_rdata", g), i_rdata, rr_data[g]);
    end
    i_req = 0; d_req = 0;
    tick();
    chk("rr_end_re", 64'(mem_re), 64'd0);

    // Reset abandons a D write-back; tie-break returns to D-first
    d_req = 1; d_we = 1; d_addr = 14'h0042; d_wdata = 64'h5555_6666_7777_8888;
    tick();
    chk("rst_mid_we", 64'(mem_we), 64'd1);
    rst_n = 0;
    tick();
    all_zero("rst_mid");
    d_req = 0; d_we = 0;
    rst_n = 1;
    i_req = 1; i_addr = 14'h0077;
    d_req = 1; d_addr = 14'h0099;
    tick();
    chk("post_rst_tie_addr", 64'(mem_addr), 64'h0099);
    chk("post_rst_tie_re", 64'(mem_re), 64'd1);
    mem_rdy = 1; mem_rd_data = 64'hCAFE_0000_0000_0001;
    tick();
    mem_rdy = 0; d_req = 0;
    chk("post_rst_d_done", 64'(d_done), 64'd1);
    chk("post_rst_d_rdata", d_rdata, 64'hCAFE_0000_0000_0001);
    tick();
    chk("post_rst_i_addr", 64'(mem_addr), 64'h0077);
    chk("post_rst_i_re", 64'(mem_re), 64'd1);
    mem_rdy = 1; mem_rd_data = 64'hCAFE_0000_0000_0002;
    tick();
    mem_rdy = 0; i_req = 0;
    chk("post_rst_i_done", 64'(i_done), 64'd1);
    chk("post_rst_i_rdata", i_rdata, 64'hCAFE_0000_0000_0002);

    // mem_rdy while idle with no requests
    tick();
    mem_rdy = 1; mem_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    chk("idle_rdy_dones", {62'd0, i_done, d_done}, 64'd0);
    chk("idle_rdy_strobes", {62'd0, mem_re, mem_we}, 64'd0);
    chk("idle_rdy_i_rdata", i_rdata, 64'hCAFE_0000_0000_0002);
    mem_rdy = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // The two strobes and the two done pulses are mutually exclusive.
  always @(negedge clk) begin
    if (mem_re && mem_we) chk("excl_strobes", 64'd1, 64'd0);
    if (i_done && d_done) chk("excl_dones", 64'd1, 64'd0);
  end

endmodule
